// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker: FSM state encoding and the
// default lab geometry, so stimulus generators and checkers agree.
package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam int DEF_N_IN    = 3;
    localparam int DEF_SETTLE  = 2;
    localparam int DEF_TIMEOUT = 1000;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/truth_table_checker_stable_detect.sv
// Input-vector stability detector: remembers the last vector, flags changes and
// raises 'settled' once the vector has been steady for SETTLE cycles.
module stable_detect #(
    parameter int W      = 3,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         track,
    input  logic         count_en,
    input  logic [W-1:0] in_vec,
    output logic         changed,
    output logic         settled
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] CNT_LAST = SW'(SETTLE - 1);

    logic [W-1:0]  prev_vec;
    logic [SW-1:0] stable_cnt;

    assign changed = (in_vec != prev_vec);
    assign settled = count_en && !changed && (stable_cnt == CNT_LAST);

    // The counter parks at its last value instead of wrapping while the vector is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_vec   <= '0;
            stable_cnt <= '0;
        end else if (load || (track && changed)) begin
            prev_vec   <= in_vec;
            stable_cnt <= '0;
        end else if (count_en && (stable_cnt != CNT_LAST)) begin
            stable_cnt <= stable_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Response-side checker for Boolean-function labs: compares settled DUT outputs
// against a latched truth table, tracking coverage, mismatches and a timeout.
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int SETTLE  = DEF_SETTLE,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2**N_IN-1:0]    truth,
    input  logic [N_IN-1:0]       in_vec,
    input  logic                  dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2**N_IN-1:0]    cov,
    output logic [CNT_W-1:0]      err_cnt,
    output logic                  first_fail_vld,
    output logic [N_IN-1:0]       first_fail_vec
);

    localparam int DEPTH = 2**N_IN;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = '1;

    state_t            state, next_state;
    logic [DEPTH-1:0]  truth_q;
    logic [TW-1:0]     tmo_cnt;
    logic              changed, settled;
    logic              load_run, finish, cmp, mismatch, tmo_hit;
    logic [DEPTH-1:0]  cov_set, cov_next;
    logic [CNT_W-1:0]  err_next;

    stable_detect #(
        .W      (N_IN),
        .SETTLE (SETTLE)
    ) u_stable (
        .clk      (clk),
        .rst      (rst),
        .load     (load_run),
        .track    (busy),
        .count_en (state == ST_WAIT),
        .in_vec   (in_vec),
        .changed  (changed),
        .settled  (settled)
    );

    assign busy     = (state == ST_WAIT) || (state == ST_HOLD);
    assign done     = (state == ST_DONE);
    assign cmp      = (state == ST_WAIT) && settled;
    assign mismatch = (dut_out != truth_q[in_vec]);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign cov_next = cmp ? (cov | cov_set) : cov;
    assign err_next = (cmp && mismatch && (err_cnt != ERR_MAX)) ? err_cnt + CNT_W'(1) : err_cnt;

    always_comb begin
        cov_set         = '0;
        cov_set[in_vec] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Finishing looks at the post-compare coverage so DONE lands right after the last new vector.
    always_comb begin
        next_state = state;
        load_run   = 1'b0;
        finish     = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load_run   = 1'b1;
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cmp) next_state = ST_HOLD;
                if ((cmp && (&cov_next)) || tmo_hit) begin
                    finish     = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_HOLD: begin
                if (changed) next_state = ST_WAIT;
                if (tmo_hit) begin
                    finish     = 1'b1;
                    next_state = ST_DONE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || load_run) begin
            truth_q        <= rst ? '0 : truth;
            cov            <= '0;
            err_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
            pass           <= 1'b0;
            tmo_cnt        <= '0;
        end else begin
            if (cmp) begin
                cov     <= cov_next;
                err_cnt <= err_next;
                if (mismatch && !first_fail_vld) begin
                    first_fail_vld <= 1'b1;
                    first_fail_vec <= in_vec;
                end
            end
            if (busy && !tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
            if (finish) pass <= (&cov_next) && (err_next == '0);
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: directed lab scenarios plus random
// runs, all checked every cycle against a run-length based reference model.
module tb_truth_table_checker;
    import truth_table_checker_pkg::*;

    localparam int N_IN    = DEF_N_IN;
    localparam int SETTLE  = DEF_SETTLE;
    localparam int TIMEOUT = 100;
    localparam int CNT_W   = 2;
    localparam int DEPTH   = 1 << N_IN;
    localparam int ERR_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst, start, dut_out;
    logic [DEPTH-1:0]  truth, d_table;
    logic [N_IN-1:0]   in_vec;
    logic              busy, done, pass, first_fail_vld;
    logic [DEPTH-1:0]  cov;
    logic [CNT_W-1:0]  err_cnt;
    logic [N_IN-1:0]   first_fail_vec;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit               m_run, m_done, m_pass, m_ffv, m_run_cmp;
    bit [DEPTH-1:0]   m_truth, m_cov;
    bit [N_IN-1:0]    m_last, m_ffvec;
    int               m_err, m_j, m_run_len;

    assign dut_out = d_table[in_vec];
    always #5 clk = ~clk;

    truth_table_checker #(
        .N_IN    (N_IN),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .truth          (truth),
        .in_vec         (in_vec),
        .dut_out        (dut_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .cov            (cov),
        .err_cnt        (err_cnt),
        .first_fail_vld (first_fail_vld),
        .first_fail_vec (first_fail_vec)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // A vector is compared once it has been sampled identically on SETTLE+1 consecutive edges.
    task automatic modelEdge();
        if (rst) begin
            m_run = 0; m_done = 0; m_pass = 0; m_cov = '0; m_err = 0;
            m_ffv = 0; m_ffvec = '0; m_truth = '0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_done = 0; m_pass = 0; m_cov = '0; m_err = 0;
                m_ffv = 0; m_ffvec = '0; m_truth = truth;
                m_j = 0; m_last = in_vec; m_run_len = 1; m_run_cmp = 0;
            end
        end else begin
            m_j++;
            if (in_vec == m_last) begin
                m_run_len++;
            end else begin
                m_last = in_vec; m_run_len = 1; m_run_cmp = 0;
            end
            if (m_run_len == SETTLE + 1 && !m_run_cmp) begin
                m_run_cmp = 1;
                m_cov[in_vec] = 1'b1;
                if (dut_out != m_truth[in_vec]) begin
                    if (m_err < ERR_MAX) m_err++;
                    if (!m_ffv) begin
                        m_ffv = 1; m_ffvec = in_vec;
                    end
                end
            end
            if (m_cov == '1 || m_j == TIMEOUT) begin
                m_run = 0; m_done = 1;
                m_pass = (m_cov == '1) && (m_err == 0);
            end
        end
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #1;
        cyc++;
        checkOutput("busy",   32'(busy),           32'(m_run));
        checkOutput("done",   32'(done),           32'(m_done));
        checkOutput("pass",   32'(pass),           32'(m_pass));
        checkOutput("cov",    32'(cov),            32'(m_cov));
        checkOutput("errcnt", 32'(err_cnt),        32'(m_err));
        checkOutput("ffvld",  32'(first_fail_vld), 32'(m_ffv));
        checkOutput("ffvec",  32'(first_fail_vec), 32'(m_ffvec));
    endtask

    task automatic applyStimulus(input logic [N_IN-1:0] vec, input int cycles);
        in_vec = vec;
        repeat (cycles) tick();
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        for (int i = 0; i < limit && !done; i++) tick();
        checkOutput("done_reached", 32'(done), 32'h1);
    endtask

    task automatic sweep(input int last_vec);
        for (int v = 0; v <= last_vec; v++) applyStimulus(N_IN'(v), 4);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start_cyc;
        rst = 1'b1; start = 1'b0; truth = '0; in_vec = '0; d_table = '0;
        tick();
        tick();
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        tick();

        $display("[TB] majority sweep, correct DUT");
        truth = 8'b1110_1000; d_table = 8'b1110_1000; in_vec = '0;
        pulseStart();
        sweep(7);
        checkOutput("s1_cov",  32'(cov),            32'hFF);
        checkOutput("s1_err",  32'(err_cnt),        32'h0);
        checkOutput("s1_done", 32'(done),           32'h1);
        checkOutput("s1_pass", 32'(pass),           32'h1);
        checkOutput("s1_ffv",  32'(first_fail_vld), 32'h0);

        $display("[TB] majority sweep, d stuck 0 at 111");
        d_table = 8'b0110_1000; in_vec = '0;
        pulseStart();
        checkOutput("s2_cleared_cov",  32'(cov),  32'h0);
        checkOutput("s2_cleared_done", 32'(done), 32'h0);
        sweep(7);
        checkOutput("s2_err",   32'(err_cnt),        32'h1);
        checkOutput("s2_ffvec", 32'(first_fail_vec), 32'h7);
        checkOutput("s2_ffv",   32'(first_fail_vld), 32'h1);
        checkOutput("s2_pass",  32'(pass),           32'h0);

        $display("[TB] partial sweep, timeout");
        d_table = 8'b1110_1000; in_vec = '0;
        pulseStart();
        start_cyc = cyc;
        sweep(5);
        waitDone(TIMEOUT + 20);
        checkOutput("s3_latency", 32'(cyc - start_cyc), 32'(TIMEOUT));
        checkOutput("s3_cov",     32'(cov),  32'h3F);
        checkOutput("s3_pass",    32'(pass), 32'h0);

        $display("[TB] never-settling input");
        in_vec = '0;
        pulseStart();
        for (int i = 0; i < TIMEOUT + 20 && !done; i++) begin
            in_vec = in_vec + 1'b1;
            tick();
        end
        checkOutput("s4_done", 32'(done), 32'h1);
        checkOutput("s4_cov",  32'(cov),  32'h0);
        checkOutput("s4_pass", 32'(pass), 32'h0);
        in_vec = 3'd5;
        pulseStart();
        applyStimulus(3'd5, 2);
        for (int i = 0; i < TIMEOUT + 20 && !done; i++) begin
            in_vec = in_vec + 1'b1;
            tick();
        end
        checkOutput("s4_one_cov", 32'(cov),  32'h20);
        checkOutput("s4_one_pass", 32'(pass), 32'h0);

        $display("[TB] saturating error counter");
        d_table = ~8'b1110_1000; in_vec = '0;
        pulseStart();
        for (int r = 0; r < 6; r++) applyStimulus(N_IN'(r % 4), 4);
        checkOutput("s5_err",   32'(err_cnt),        32'(ERR_MAX));
        checkOutput("s5_ffvec", 32'(first_fail_vec), 32'h0);

        $display("[TB] reset mid-run and ignored start");
        rst = 1'b1; tick(); rst = 1'b0;
        d_table = 8'b1110_1000; in_vec = '0;
        pulseStart();
        sweep(2);
        checkOutput("s6_cov3", 32'(cov), 32'h07);
        in_vec = 3'd2;
        pulseStart();
        checkOutput("s6_ign_busy", 32'(busy), 32'h1);
        checkOutput("s6_ign_cov",  32'(cov),  32'h07);
        rst = 1'b1; tick(); rst = 1'b0;
        checkOutput("s6_rst_busy", 32'(busy),    32'h0);
        checkOutput("s6_rst_cov",  32'(cov),     32'h0);
        checkOutput("s6_rst_err",  32'(err_cnt), 32'h0);

        $display("[TB] random runs");
        for (int run = 0; run < 20; run++) begin
            truth   = DEPTH'($urandom);
            d_table = truth;
            if ($urandom_range(0, 2) == 0) d_table[$urandom_range(0, DEPTH - 1)] ^= 1'b1;
            in_vec = N_IN'($urandom_range(0, DEPTH - 1));
            pulseStart();
            for (int k = 0; k < 4 * TIMEOUT && !done; k++) begin
                int n;
                in_vec = N_IN'($urandom_range(0, DEPTH - 1));
                n = $urandom_range(1, 5);
                for (int c = 0; c < n && !done; c++) begin
                    start = ($urandom_range(0, 15) == 0);
                    if ($urandom_range(0, 7) == 0) truth = DEPTH'($urandom);
                    tick();
                    start = 1'b0;
                end
            end
            waitDone(TIMEOUT + 20);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
